// File: rtl/dna_reader_ctrl_if.sv
// rtl/dna_reader_ctrl_if.sv - host request/result and DNA primitive signal bundle
interface dna_reader_ctrl_if #(
  parameter int DNA_WIDTH = 57
);
  logic                 start;
  logic                 busy;
  logic                 dna_valid;
  logic [DNA_WIDTH-1:0] dna_value;
  logic                 dna_read;
  logic                 dna_shift;
  logic                 dna_din;
  logic                 dna_dout;

  modport master (
    input  start,
    input  dna_dout,
    output busy,
    output dna_valid,
    output dna_value,
    output dna_read,
    output dna_shift,
    output dna_din
  );

  modport slave (
    output start,
    output dna_dout,
    input  busy,
    input  dna_valid,
    input  dna_value,
    input  dna_read,
    input  dna_shift,
    input  dna_din
  );
endinterface

// File: rtl/dna_reader_ctrl.sv
// rtl/dna_reader_ctrl.sv - DNA_PORT read sequencer; DNA_AUTOSTART_EN enables one read after reset
module dna_reader_ctrl #(
  parameter int DNA_WIDTH = 57,
  parameter int CLK_DIV   = 1
) (
  input logic               CLK,
  input logic               RST_N,
  dna_reader_ctrl_if.master bus
);

  localparam int BW = $clog2(DNA_WIDTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DNA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DW-1:0]        div_cnt, div_cnt_n;
  logic [DNA_WIDTH-1:0] sreg, sreg_n;
  logic [DNA_WIDTH-1:0] value_q, value_n;
  logic                 valid_q, valid_n;
  logic                 busy_q, busy_n;
  logic                 read_q, read_n;
  logic                 shift_q, shift_n;
  logic                 start_eff;

`ifdef DNA_AUTOSTART_EN
  logic auto_q;

  // One-shot request armed by reset; the FSM is in IDLE in the first cycle so it is always consumed there
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) auto_q <= 1'b1;
    else        auto_q <= 1'b0;
  end

  assign start_eff = bus.start | auto_q;
`else
  assign start_eff = bus.start;
`endif

  // Next-state, counters, shift register and the registered versions of every output
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    sreg_n    = sreg;
    value_n   = value_q;
    valid_n   = valid_q;
    case (state)
      IDLE: begin
        if (start_eff) state_n = LOAD;
      end
      LOAD: begin
        state_n   = SHIFT;
        bit_cnt_n = '0;
        div_cnt_n = '0;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          // dna_shift is high this cycle, so DOUT still shows the bit being consumed
          sreg_n    = {sreg[DNA_WIDTH-2:0], bus.dna_dout};
          bit_cnt_n = bit_cnt + BW'(1);
          div_cnt_n = '0;
          if (bit_cnt == BIT_LAST) begin
            state_n = DONE;
            value_n = sreg_n;
            valid_n = 1'b1;
          end
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
      DONE: begin
        if (start_eff) begin
          state_n = LOAD;
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n  = (state_n == LOAD) || (state_n == SHIFT);
    read_n  = (state_n == LOAD);
    shift_n = (state_n == SHIFT) && (div_cnt_n == DIV_LAST);
  end

  // State and output registers; reset aborts any read and discards partial data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
      sreg    <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      read_q  <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
      sreg    <= sreg_n;
      value_q <= value_n;
      valid_q <= valid_n;
      busy_q  <= busy_n;
      read_q  <= read_n;
      shift_q <= shift_n;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.dna_valid = valid_q;
  assign bus.dna_value = value_q;
  assign bus.dna_read  = read_q;
  assign bus.dna_shift = shift_q;
  assign bus.dna_din   = 1'b0;

endmodule

// File: tb/tb_dna_reader_ctrl.sv
// tb/tb_dna_reader_ctrl.sv - randomized self-checking bench for dna_reader_ctrl
`timescale 1ns/1ps
module tb_dna_reader_ctrl;

  localparam int W    = 57;
  localparam int DIV4 = 4;

  logic         CLK    = 1'b0;
  logic         RST_N  = 1'b1;
  logic         start  = 1'b0;
  logic         start4 = 1'b0;
  logic [W-1:0] prim_id = '0;
  logic [W-1:0] prim_sr = '0;
  int           checks = 0;
  int           errors = 0;

  always #5 CLK = ~CLK;

  dna_reader_ctrl_if #(.DNA_WIDTH(W)) bus ();
  dna_reader_ctrl_if #(.DNA_WIDTH(W)) bus4 ();

  dna_reader_ctrl #(.DNA_WIDTH(W), .CLK_DIV(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus)
  );
  dna_reader_ctrl #(.DNA_WIDTH(W), .CLK_DIV(DIV4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus4)
  );

  assign bus.start  = start;
  assign bus4.start = start4;

  // Behavioural DNA primitive: READ loads the ID, SHIFT moves the next bit onto DOUT
  always @(posedge CLK) begin
    if (bus.dna_read)       prim_sr <= prim_id;
    else if (bus.dna_shift) prim_sr <= {prim_sr[W-2:0], bus.dna_din};
  end
  assign bus.dna_dout  = prim_sr[W-1];
  assign bus4.dna_dout = 1'b0;

  function automatic logic [W-1:0] rand_id();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Runs one read from a start pulse and reports what was observed (k = cycles after the start cycle)
  task automatic measure_read(input bit sel4, input int div, input int poke_at,
                              output int t_read, output int t_first, output int t_valid,
                              output int n_read, output int n_shift, output int n_both,
                              output int n_gap, output logic [W-1:0] val);
    int k, last;
    logic r, s, v;
    t_read = -1; t_first = -1; t_valid = -1;
    n_read = 0; n_shift = 0; n_both = 0; n_gap = 0; last = -1; val = '0;
    @(negedge CLK);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    k = 0;
    while (t_valid < 0 && k < 400) begin
      @(negedge CLK); k++;
      start = 1'b0; start4 = 1'b0;
      r = sel4 ? bus4.dna_read  : bus.dna_read;
      s = sel4 ? bus4.dna_shift : bus.dna_shift;
      v = sel4 ? bus4.dna_valid : bus.dna_valid;
      if (r) begin n_read++; if (t_read < 0) t_read = k; end
      if (r && s) n_both++;
      if (s) begin
        n_shift++;
        if (t_first < 0) t_first = k;
        else if (k - last != div) n_gap++;
        last = k;
        if (n_shift == poke_at) begin
          if (sel4) start4 = 1'b1; else start = 1'b1;
        end
      end
      if (v) begin
        t_valid = k;
        val = sel4 ? bus4.dna_value : bus.dna_value;
      end
    end
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic test_reset();
    int k, nr, nb, tv, tr;
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.dna_valid, bus.dna_read, bus.dna_shift} !== 4'b0000 || bus.dna_value !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b/%h required 0000/0", {bus.busy, bus.dna_valid, bus.dna_read, bus.dna_shift}, bus.dna_value);
    end
    checks++;
    if ({bus4.busy, bus4.dna_valid, bus4.dna_read, bus4.dna_shift} !== 4'b0000 || bus4.dna_value !== '0) begin
      errors++; $display("FAIL reset_outputs_div4: got %b/%h required 0000/0", {bus4.busy, bus4.dna_valid, bus4.dna_read, bus4.dna_shift}, bus4.dna_value);
    end
    checks++;
    if (bus.dna_din !== 1'b0) begin errors++; $display("FAIL din_const: got %b required 0", bus.dna_din); end
    prim_id = 57'h1_2345_6789_ABCD_EF;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    k = 0; nr = 0; nb = 0; tv = -1; tr = -1;
`ifdef DNA_AUTOSTART_EN
    while (k < 300 && !(tv >= 0 && bus4.dna_valid)) begin
      @(negedge CLK); k++;
      if (bus.dna_read) begin nr++; if (tr < 0) tr = k; end
      if (bus.dna_valid && tv < 0) tv = k;
    end
    checks++; if (tr !== 1)  begin errors++; $display("FAIL autostart_read_cycle: got %0d required 1", tr); end
    checks++; if (tv !== 59) begin errors++; $display("FAIL autostart_valid_cycle: got %0d required 59", tv); end
    checks++; if (nr !== 1)  begin errors++; $display("FAIL autostart_read_count: got %0d required 1", nr); end
    checks++; if (bus.dna_value !== prim_id) begin errors++; $display("FAIL autostart_value: got %h required %h", bus.dna_value, prim_id); end
`else
    repeat (20) begin
      @(negedge CLK); k++;
      if (bus.dna_read || bus4.dna_read) nr++;
      if (bus.busy || bus4.busy) nb++;
    end
    checks++; if (nr !== 0) begin errors++; $display("FAIL idle_no_read: got %0d reads required 0", nr); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL idle_not_busy: got %0d busy cycles required 0", nb); end
`endif
  endtask

  task automatic test_basic();
    int tr, tf, tv, nr, ns, nb, ng;
    logic [W-1:0] val, exp_v;
    exp_v = 57'h1_2345_6789_ABCD_EF;
    prim_id = exp_v;
    measure_read(1'b0, 1, 0, tr, tf, tv, nr, ns, nb, ng, val);
    checks++; if (tr !== 1)  begin errors++; $display("FAIL basic_read_cycle: got %0d required 1", tr); end
    checks++; if (tf !== 2)  begin errors++; $display("FAIL basic_first_shift: got %0d required 2", tf); end
    checks++; if (tv !== 59) begin errors++; $display("FAIL basic_valid_cycle: got %0d required 59", tv); end
    checks++; if (nr !== 1)  begin errors++; $display("FAIL basic_read_count: got %0d required 1", nr); end
    checks++; if (ns !== W)  begin errors++; $display("FAIL basic_shift_count: got %0d required %0d", ns, W); end
    checks++; if (nb !== 0 || ng !== 0) begin errors++; $display("FAIL basic_overlap_gap: got %0d/%0d required 0/0", nb, ng); end
    checks++; if (val !== exp_v) begin errors++; $display("FAIL basic_value: got %h required %h", val, exp_v); end
  endtask

  task automatic test_random();
    int tr, tf, tv, nr, ns, nb, ng;
    logic [W-1:0] val, exp_v;
    for (int i = 0; i < 4; i++) begin
      exp_v = rand_id();
      prim_id = exp_v;
      measure_read(1'b0, 1, 0, tr, tf, tv, nr, ns, nb, ng, val);
      checks++; if (tv !== 59 || ns !== W || nr !== 1) begin errors++; $display("FAIL random_timing[%0d]: got valid %0d shifts %0d reads %0d required 59/%0d/1", i, tv, ns, nr, W); end
      checks++; if (val !== exp_v) begin errors++; $display("FAIL random_value[%0d]: got %h required %h", i, val, exp_v); end
    end
  endtask

  task automatic test_clkdiv4();
    int tr, tf, tv, nr, ns, nb, ng;
    logic [W-1:0] val;
    measure_read(1'b1, DIV4, 0, tr, tf, tv, nr, ns, nb, ng, val);
    checks++; if (tr !== 1) begin errors++; $display("FAIL div4_read_cycle: got %0d required 1", tr); end
    checks++; if (tf !== 1 + DIV4) begin errors++; $display("FAIL div4_first_shift: got %0d required %0d", tf, 1 + DIV4); end
    checks++; if (tv !== 2 + W * DIV4) begin errors++; $display("FAIL div4_valid_cycle: got %0d required %0d", tv, 2 + W * DIV4); end
    checks++; if (ns !== W || ng !== 0) begin errors++; $display("FAIL div4_shift_spacing: got %0d shifts %0d bad gaps required %0d/0", ns, ng, W); end
    checks++; if (val !== '0) begin errors++; $display("FAIL div4_value: got %h required 0", val); end
  endtask

  task automatic test_start_while_busy();
    int tr, tf, tv, nr, ns, nb, ng;
    logic [W-1:0] val, exp_v;
    exp_v = rand_id();
    prim_id = exp_v;
    measure_read(1'b0, 1, 20, tr, tf, tv, nr, ns, nb, ng, val);
    checks++; if (tv !== 59) begin errors++; $display("FAIL busy_start_valid_cycle: got %0d required 59", tv); end
    checks++; if (nr !== 1 || ns !== W) begin errors++; $display("FAIL busy_start_restart: got reads %0d shifts %0d required 1/%0d", nr, ns, W); end
    checks++; if (val !== exp_v) begin errors++; $display("FAIL busy_start_value: got %h required %h", val, exp_v); end
  endtask

  task automatic test_reset_mid_read();
    int k, ns, tr, tf, tv, nr, nsh, nb, ng;
    logic [W-1:0] val, exp_v;
    prim_id = rand_id();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    ns = 0; k = 0;
    while (ns < 30 && k < 100) begin
      if (bus.dna_shift) ns++;
      if (ns < 30) begin @(negedge CLK); k++; end
    end
    checks++; if (ns !== 30) begin errors++; $display("FAIL midreset_reach_bit30: got %0d shifts required 30", ns); end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.dna_valid, bus.dna_read, bus.dna_shift} !== 4'b0000 || bus.dna_value !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b/%h required 0000/0", {bus.busy, bus.dna_valid, bus.dna_read, bus.dna_shift}, bus.dna_value);
    end
    @(negedge CLK); RST_N = 1'b1;
    k = 0; nr = 0;
`ifdef DNA_AUTOSTART_EN
    while (k < 300 && !(bus.dna_valid && bus4.dna_valid)) begin @(negedge CLK); k++; end
    checks++; if (!bus.dna_valid) begin errors++; $display("FAIL midreset_autostart: got valid %b required 1", bus.dna_valid); end
`else
    repeat (5) begin @(negedge CLK); if (bus.dna_read || bus.busy || bus.dna_valid) nr++; end
    checks++; if (nr !== 0) begin errors++; $display("FAIL midreset_idle: got %0d active cycles required 0", nr); end
`endif
    exp_v = rand_id();
    prim_id = exp_v;
    measure_read(1'b0, 1, 0, tr, tf, tv, nr, nsh, nb, ng, val);
    checks++; if (tv !== 59 || nsh !== W) begin errors++; $display("FAIL midreset_reread_timing: got valid %0d shifts %0d required 59/%0d", tv, nsh, W); end
    checks++; if (val !== exp_v) begin errors++; $display("FAIL midreset_reread_value: got %h required %h", val, exp_v); end
  endtask

  task automatic test_reread();
    int k, tv, held_bad;
    logic [W-1:0] old_v, exp_v;
    checks++; if (bus.dna_valid !== 1'b1) begin errors++; $display("FAIL reread_precond_valid: got %b required 1", bus.dna_valid); end
    old_v = bus.dna_value;
    exp_v = {W{1'b1}};
    prim_id = exp_v;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    checks++; if (bus.dna_valid !== 1'b0) begin errors++; $display("FAIL reread_valid_drop: got %b required 0", bus.dna_valid); end
    k = 1; tv = -1; held_bad = 0;
    while (tv < 0 && k < 200) begin
      if (bus.dna_valid) tv = k;
      else begin
        if (bus.dna_value !== old_v) held_bad++;
        @(negedge CLK); k++;
      end
    end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL reread_old_held: got %0d changed cycles required 0", held_bad); end
    checks++; if (tv !== 59) begin errors++; $display("FAIL reread_valid_cycle: got %0d required 59", tv); end
    checks++; if (bus.dna_value !== 57'h1FF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL reread_value: got %h required %h", bus.dna_value, 57'h1FF_FFFF_FFFF_FFFF); end
  endtask

  task automatic test_back_to_back();
    int k, tv1, tv2, tr2, nvalid;
    logic [W-1:0] id_a, id_b, v1, v2;
    id_a = rand_id(); id_b = rand_id();
    prim_id = id_a;
    @(negedge CLK); start = 1'b1;
    k = 0; tv1 = -1; tv2 = -1; tr2 = -1; nvalid = 0; v1 = '0; v2 = '0;
    while (tv2 < 0 && k < 300) begin
      @(negedge CLK); k++;
      if (k == 2) prim_id = id_b;
      if (bus.dna_valid) begin
        nvalid++;
        if (tv1 < 0) begin tv1 = k; v1 = bus.dna_value; end
        else if (tr2 >= 0) begin tv2 = k; v2 = bus.dna_value; start = 1'b0; end
      end
      if (bus.dna_read && tv1 >= 0 && tr2 < 0) tr2 = k;
    end
    start = 1'b0;
    checks++; if (tv1 !== 59 || tr2 !== 60 || tv2 !== 118) begin errors++; $display("FAIL b2b_timing: got %0d/%0d/%0d required 59/60/118", tv1, tr2, tv2); end
    checks++; if (nvalid !== 2) begin errors++; $display("FAIL b2b_done_cycles: got %0d valid cycles required 2", nvalid); end
    checks++; if (v1 !== id_a || v2 !== id_b) begin errors++; $display("FAIL b2b_values: got %h/%h required %h/%h", v1, v2, id_a, id_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_clkdiv4();
    test_start_while_busy();
    test_reset_mid_read();
    test_reread();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
